// File: rtl/mor1kx_pcu_event_gen.sv
// Event conditioning ahead of the performance counter unit: turns raw pipeline, LSU,
// cache and MMU status into registered single-cycle pulses, masked by a debug freeze.
module mor1kx_pcu_event_gen #(
  parameter string FEATURE_DCACHE = "ENABLED",
  parameter string FEATURE_ICACHE = "ENABLED",
  parameter string FEATURE_DMMU   = "ENABLED",
  parameter string FEATURE_IMMU   = "ENABLED"
) (
  input  logic clk,
  input  logic rst,
  input  logic du_stall_i,
  input  logic pipeline_flush_i,
  input  logic lsu_valid_i,
  input  logic lsu_ack_i,
  input  logic lsu_we_i,
  input  logic ifetch_ack_i,
  input  logic dc_miss_i,
  input  logic dc_refill_done_i,
  input  logic ic_miss_i,
  input  logic ic_refill_done_i,
  input  logic fetch_stall_i,
  input  logic lsu_stall_i,
  input  logic branch_mispredict_i,
  input  logic dtlb_miss_i,
  input  logic itlb_miss_i,
  input  logic datadep_stall_i,
  output logic pcu_event_load_o,
  output logic pcu_event_store_o,
  output logic pcu_event_ifetch_o,
  output logic pcu_event_dcache_miss_o,
  output logic pcu_event_icache_miss_o,
  output logic pcu_event_ifetch_stall_o,
  output logic pcu_event_lsu_stall_o,
  output logic pcu_event_brn_stall_o,
  output logic pcu_event_dtlb_miss_o,
  output logic pcu_event_itlb_miss_o,
  output logic pcu_event_datadep_stall_o
);

  localparam bit HasDcache = (FEATURE_DCACHE != "NONE");
  localparam bit HasIcache = (FEATURE_ICACHE != "NONE");
  localparam bit HasDmmu   = (FEATURE_DMMU != "NONE");
  localparam bit HasImmu   = (FEATURE_IMMU != "NONE");

  typedef enum logic {StIdle, StRefill} cache_state_e;

  cache_state_e dc_state_q;
  cache_state_e ic_state_q;
  logic         dtlb_miss_q;
  logic         itlb_miss_q;
  logic         en;

  assign en = ~du_stall_i;

  // Simple level/pulse events: one registered stage, gated by the freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcu_event_load_o          <= 1'b0;
      pcu_event_store_o         <= 1'b0;
      pcu_event_ifetch_o        <= 1'b0;
      pcu_event_ifetch_stall_o  <= 1'b0;
      pcu_event_lsu_stall_o     <= 1'b0;
      pcu_event_brn_stall_o     <= 1'b0;
      pcu_event_datadep_stall_o <= 1'b0;
    end else begin
      pcu_event_load_o          <= lsu_valid_i & lsu_ack_i & ~lsu_we_i & en;
      pcu_event_store_o         <= lsu_valid_i & lsu_ack_i & lsu_we_i & en;
      pcu_event_ifetch_o        <= ifetch_ack_i & ~pipeline_flush_i & en;
      pcu_event_ifetch_stall_o  <= fetch_stall_i & ~pipeline_flush_i & en;
      pcu_event_lsu_stall_o     <= lsu_stall_i & ~pipeline_flush_i & en;
      pcu_event_brn_stall_o     <= branch_mispredict_i & en;
      pcu_event_datadep_stall_o <= datadep_stall_i & ~pipeline_flush_i & en;
    end
  end

  // TLB misses count the rising edge only; the delay registers run during a freeze
  // so a miss that begins while frozen is never counted afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dtlb_miss_q           <= 1'b0;
      itlb_miss_q           <= 1'b0;
      pcu_event_dtlb_miss_o <= 1'b0;
      pcu_event_itlb_miss_o <= 1'b0;
    end else begin
      dtlb_miss_q           <= dtlb_miss_i;
      itlb_miss_q           <= itlb_miss_i;
      pcu_event_dtlb_miss_o <= HasDmmu & dtlb_miss_i & ~dtlb_miss_q & en;
      pcu_event_itlb_miss_o <= HasImmu & itlb_miss_i & ~itlb_miss_q & en;
    end
  end

  // D-cache miss FSM: a pulse only on IDLE->REFILL; misses seen during REFILL are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_state_q              <= StIdle;
      pcu_event_dcache_miss_o <= 1'b0;
    end else begin
      pcu_event_dcache_miss_o <= 1'b0;
      unique case (dc_state_q)
        StIdle: begin
          if (HasDcache && dc_miss_i) begin
            dc_state_q              <= StRefill;
            pcu_event_dcache_miss_o <= en;
          end
        end
        StRefill: begin
          if (dc_refill_done_i || pipeline_flush_i) dc_state_q <= StIdle;
        end
        default: dc_state_q <= StIdle;
      endcase
    end
  end

  // I-cache miss FSM, same behaviour as the D-cache one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_state_q              <= StIdle;
      pcu_event_icache_miss_o <= 1'b0;
    end else begin
      pcu_event_icache_miss_o <= 1'b0;
      unique case (ic_state_q)
        StIdle: begin
          if (HasIcache && ic_miss_i) begin
            ic_state_q              <= StRefill;
            pcu_event_icache_miss_o <= en;
          end
        end
        StRefill: begin
          if (ic_refill_done_i || pipeline_flush_i) ic_state_q <= StIdle;
        end
        default: ic_state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_pcu_event_gen.sv
// Directed bench for mor1kx_pcu_event_gen: full-featured DUT plus an I-cache-less copy.
module tb_mor1kx_pcu_event_gen;

  localparam int BLoad = 10, BStore = 9, BIfetch = 8, BDc = 7, BIc = 6, BIfs = 5;
  localparam int BLsus = 4, BBrn = 3, BDtlb = 2, BItlb = 1, BDd = 0;

  logic clk = 1'b0;
  logic rst;
  logic du_stall, flush, lsu_valid, lsu_ack, lsu_we, ifetch_ack;
  logic dc_miss, dc_done, ic_miss, ic_done, fetch_stall, lsu_stall;
  logic br_mis, dtlb_miss, itlb_miss, dd_stall;
  logic [10:0] ev;
  logic [10:0] ev2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mor1kx_pcu_event_gen dut (
    .clk(clk), .rst(rst), .du_stall_i(du_stall), .pipeline_flush_i(flush),
    .lsu_valid_i(lsu_valid), .lsu_ack_i(lsu_ack), .lsu_we_i(lsu_we),
    .ifetch_ack_i(ifetch_ack), .dc_miss_i(dc_miss), .dc_refill_done_i(dc_done),
    .ic_miss_i(ic_miss), .ic_refill_done_i(ic_done), .fetch_stall_i(fetch_stall),
    .lsu_stall_i(lsu_stall), .branch_mispredict_i(br_mis), .dtlb_miss_i(dtlb_miss),
    .itlb_miss_i(itlb_miss), .datadep_stall_i(dd_stall),
    .pcu_event_load_o(ev[BLoad]), .pcu_event_store_o(ev[BStore]),
    .pcu_event_ifetch_o(ev[BIfetch]), .pcu_event_dcache_miss_o(ev[BDc]),
    .pcu_event_icache_miss_o(ev[BIc]), .pcu_event_ifetch_stall_o(ev[BIfs]),
    .pcu_event_lsu_stall_o(ev[BLsus]), .pcu_event_brn_stall_o(ev[BBrn]),
    .pcu_event_dtlb_miss_o(ev[BDtlb]), .pcu_event_itlb_miss_o(ev[BItlb]),
    .pcu_event_datadep_stall_o(ev[BDd])
  );

  mor1kx_pcu_event_gen #(.FEATURE_ICACHE("NONE")) dut_noic (
    .clk(clk), .rst(rst), .du_stall_i(du_stall), .pipeline_flush_i(flush),
    .lsu_valid_i(lsu_valid), .lsu_ack_i(lsu_ack), .lsu_we_i(lsu_we),
    .ifetch_ack_i(ifetch_ack), .dc_miss_i(dc_miss), .dc_refill_done_i(dc_done),
    .ic_miss_i(ic_miss), .ic_refill_done_i(ic_done), .fetch_stall_i(fetch_stall),
    .lsu_stall_i(lsu_stall), .branch_mispredict_i(br_mis), .dtlb_miss_i(dtlb_miss),
    .itlb_miss_i(itlb_miss), .datadep_stall_i(dd_stall),
    .pcu_event_load_o(ev2[BLoad]), .pcu_event_store_o(ev2[BStore]),
    .pcu_event_ifetch_o(ev2[BIfetch]), .pcu_event_dcache_miss_o(ev2[BDc]),
    .pcu_event_icache_miss_o(ev2[BIc]), .pcu_event_ifetch_stall_o(ev2[BIfs]),
    .pcu_event_lsu_stall_o(ev2[BLsus]), .pcu_event_brn_stall_o(ev2[BBrn]),
    .pcu_event_dtlb_miss_o(ev2[BDtlb]), .pcu_event_itlb_miss_o(ev2[BItlb]),
    .pcu_event_datadep_stall_o(ev2[BDd])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs set before step() are seen on the next edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {du_stall, flush, lsu_valid, lsu_ack, lsu_we, ifetch_ack} = '0;
    {dc_miss, dc_done, ic_miss, ic_done, fetch_stall, lsu_stall} = '0;
    {br_mis, dtlb_miss, itlb_miss, dd_stall} = '0;
  endtask

  logic [10:0] one;
  logic [9:0]  dc_miss_v, dc_done_v, dc_exp_v;
  logic [8:0]  tlb_v, tlb_exp_v;
  logic [3:0]  fl_v, st_exp_v;

  initial begin
    one = 11'd1;
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    check("reset_outputs", 32'(ev), 32'd0);
    check("reset_outputs_noic", 32'(ev2), 32'd0);
    rst = 1'b0;
    step();
    check("idle", 32'(ev), 32'd0);

    // Loads then stores, one ack each, separated by idle cycles.
    for (int i = 0; i < 5; i++) begin
      lsu_valid = 1'b1; lsu_ack = 1'b1; lsu_we = (i >= 3);
      step();
      check(i < 3 ? "load_pulse" : "store_pulse", 32'(ev), 32'(one << (i < 3 ? BLoad : BStore)));
      lsu_valid = 1'b0; lsu_ack = 1'b0; lsu_we = 1'b0;
      step();
      check("lsu_gap", 32'(ev), 32'd0);
    end
    lsu_valid = 1'b1;
    step();
    check("lsu_valid_no_ack", 32'(ev), 32'd0);
    lsu_valid = 1'b0;

    // ifetch, with and without flush.
    ifetch_ack = 1'b1; flush = 1'b1;
    step();
    check("ifetch_flushed", 32'(ev), 32'd0);
    flush = 1'b0;
    step();
    check("ifetch_pulse", 32'(ev), 32'(one << BIfetch));
    ifetch_ack = 1'b0;

    // D-cache: refill_done coincides with a held miss -> no pulse; later miss counted.
    dc_miss_v = 10'b0110111111;
    dc_done_v = 10'b1000100000;
    dc_exp_v  = 10'b0010000001;
    for (int i = 0; i < 10; i++) begin
      dc_miss = dc_miss_v[i]; dc_done = dc_done_v[i];
      step();
      check("dcache_seq", 32'(ev), dc_exp_v[i] ? 32'(one << BDc) : 32'd0);
    end
    dc_miss = 1'b0; dc_done = 1'b0;

    // TLB edges: high 5, low 1, high 2, low 1 -> pulses on both rising edges.
    tlb_v     = 9'b011011111;
    tlb_exp_v = 9'b001000001;
    for (int i = 0; i < 9; i++) begin
      dtlb_miss = tlb_v[i]; itlb_miss = tlb_v[i];
      step();
      check("tlb_seq", 32'(ev), tlb_exp_v[i] ? 32'(one << BDtlb | one << BItlb) : 32'd0);
    end
    dtlb_miss = 1'b0; itlb_miss = 1'b0;

    // Stall levels for 4 cycles, flush in the 3rd; mispredict pulse in the 1st.
    fl_v     = 4'b0100;
    st_exp_v = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      lsu_stall = 1'b1; fetch_stall = 1'b1; dd_stall = 1'b1;
      flush = fl_v[i]; br_mis = (i == 0);
      step();
      check("stall_seq", 32'(ev),
            (st_exp_v[i] ? 32'(one << BLsus | one << BIfs | one << BDd) : 32'd0) |
            (i == 0 ? 32'(one << BBrn) : 32'd0));
    end
    clear_inputs();
    step();
    check("stall_end", 32'(ev), 32'd0);

    // Debug freeze: I-cache miss starts and fetch acks toggle, all masked.
    du_stall = 1'b1; ic_miss = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifetch_ack = i[0]; lsu_valid = 1'b1; lsu_ack = 1'b1;
      step();
      check("freeze_masked", 32'(ev), 32'd0);
      check("freeze_masked_noic", 32'(ev2), 32'd0);
    end
    du_stall = 1'b0; ifetch_ack = 1'b0; lsu_valid = 1'b0; lsu_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_freeze_refill", 32'(ev), 32'd0);
    end
    ic_done = 1'b1;
    step();
    check("ic_done_with_miss", 32'(ev), 32'd0);
    ic_done = 1'b0;
    step();
    check("ic_new_miss", 32'(ev), 32'(one << BIc));
    check("ic_new_miss_noic", 32'(ev2), 32'd0);
    step();
    check("ic_held_in_refill", 32'(ev), 32'd0);
    ic_miss = 1'b0;
    ic_done = 1'b1;
    step();
    ic_done = 1'b0;

    // Async reset mid-refill: output drops without an edge, FSM returns to IDLE.
    ic_miss = 1'b1;
    step();
    check("ic_miss_pre_reset", 32'(ev), 32'(one << BIc));
    #2 rst = 1'b1;
    #1 check("async_reset_drop", 32'(ev), 32'd0);
    ic_miss = 1'b0;
    step();
    rst = 1'b0;
    ic_miss = 1'b1;
    step();
    check("ic_idle_after_reset", 32'(ev), 32'(one << BIc));
    check("noic_always_zero", 32'(ev2), 32'd0);
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
